// File: rtl/test_finisher.sv
// Test finisher: watches per-slot tohost-style status words and reports a sticky pass/fail verdict.
// Optional watchdog is compiled in only when TEST_FINISHER_TIMEOUT_EN is defined.
module test_finisher #(
  parameter int unsigned NCONCURRENT    = 1,
  parameter int unsigned REGBYTES       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned W  = REGBYTES * 8,
  localparam int unsigned IW = (NCONCURRENT > 1) ? $clog2(NCONCURRENT) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [W-1:0]           status_regs [NCONCURRENT],
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [IW-1:0]          fail_index,
  output logic [W-2:0]           fail_code,
  output logic [NCONCURRENT-1:0] finished_mask,
  output logic                   timeout,
  output logic [63:0]            cycle_count
);

  if (NCONCURRENT == 0 || NCONCURRENT > 32 || REGBYTES == 0 || TIMEOUT_CYCLES == 0)
  begin : g_param_check
    $error("test_finisher: parameter out of range");
  end

  logic                   done_q, pass_q, fail_q;
  logic [IW-1:0]          fail_index_q;
  logic [W-2:0]           fail_code_q;
  logic [NCONCURRENT-1:0] mask_q, mask_d, rep_new;
  logic [W-2:0]           codes_q [NCONCURRENT];
  logic [63:0]            count_q;

  logic                   fail_hit, codes_bad;
  logic [IW-1:0]          hit_index;
  logic [W-2:0]           hit_code;

  // Descending scan so the lowest failing slot is the one left selected.
  always_comb begin
    rep_new   = '0;
    fail_hit  = 1'b0;
    codes_bad = 1'b0;
    hit_index = '0;
    hit_code  = '0;
    for (int i = NCONCURRENT - 1; i >= 0; i--) begin
      rep_new[i] = ~done_q & status_regs[i][0] & ~mask_q[i];
      if (codes_q[i] != '0) codes_bad = 1'b1;
      if (rep_new[i] && status_regs[i][W-1:1] != '0) begin
        fail_hit  = 1'b1;
        hit_index = IW'(i);
        hit_code  = status_regs[i][W-1:1];
      end
    end
    mask_d = mask_q | rep_new;
  end

`ifdef TEST_FINISHER_TIMEOUT_EN
  logic timeout_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_index_q <= '0;
      fail_code_q  <= '0;
      mask_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < NCONCURRENT; i++) codes_q[i] <= '0;
`ifdef TEST_FINISHER_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else if (!done_q) begin
      count_q <= count_q + 64'd1;
      mask_q  <= mask_d;
      for (int i = 0; i < NCONCURRENT; i++) begin
        if (rep_new[i]) codes_q[i] <= status_regs[i][W-1:1];
      end
      if (fail_hit) begin
        done_q       <= 1'b1;
        fail_q       <= 1'b1;
        fail_index_q <= hit_index;
        fail_code_q  <= hit_code;
      end else if (&mask_d && !codes_bad) begin
        done_q <= 1'b1;
        pass_q <= 1'b1;
`ifdef TEST_FINISHER_TIMEOUT_EN
      end else if (rep_new == '0 && count_q >= 64'(TIMEOUT_CYCLES)) begin
        // A report arriving this cycle defers the watchdog by one cycle.
        done_q       <= 1'b1;
        fail_q       <= 1'b1;
        timeout_q    <= 1'b1;
        fail_index_q <= '0;
        fail_code_q  <= '1;
`endif
      end
    end
  end

`ifdef TEST_FINISHER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign fail_index    = fail_index_q;
  assign fail_code     = fail_code_q;
  assign finished_mask = mask_q;
  assign cycle_count   = count_q;

endmodule

// File: tb/tb_test_finisher.sv
// Directed bench for test_finisher: one single-slot and one four-slot instance share clock/reset.
module tb_test_finisher;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] st1 [1];
  logic [31:0] st4 [4];

  logic        d1_done, d1_pass, d1_fail, d1_timeout;
  logic [0:0]  d1_idx, d1_mask;
  logic [30:0] d1_code;
  logic [63:0] d1_count;

  logic        d4_done, d4_pass, d4_fail, d4_timeout;
  logic [1:0]  d4_idx;
  logic [3:0]  d4_mask;
  logic [30:0] d4_code;
  logic [63:0] d4_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  test_finisher #(.NCONCURRENT(1), .REGBYTES(4), .TIMEOUT_CYCLES(100)) dut1 (
    .clock(clock), .reset(reset), .status_regs(st1),
    .done(d1_done), .pass(d1_pass), .fail(d1_fail), .fail_index(d1_idx),
    .fail_code(d1_code), .finished_mask(d1_mask), .timeout(d1_timeout),
    .cycle_count(d1_count)
  );

  test_finisher #(.NCONCURRENT(4), .REGBYTES(4)) dut4 (
    .clock(clock), .reset(reset), .status_regs(st4),
    .done(d4_done), .pass(d4_pass), .fail(d4_fail), .fail_index(d4_idx),
    .fail_code(d4_code), .finished_mask(d4_mask), .timeout(d4_timeout),
    .cycle_count(d4_count)
  );

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    st1[0] = '0;
    for (int i = 0; i < 4; i++) st4[i] = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({d1_done, d1_pass, d1_fail, d1_timeout, d1_idx, d1_code, d1_mask} !== '0 || d1_count !== 64'd0) begin
      errors++;
      $display("FAIL reset_d1: got done=%0b pass=%0b fail=%0b mask=%0b count=%0d, want all 0",
               d1_done, d1_pass, d1_fail, d1_mask, d1_count);
    end
    checks++;
    if ({d4_done, d4_pass, d4_fail, d4_timeout, d4_idx, d4_code, d4_mask} !== '0 || d4_count !== 64'd0) begin
      errors++;
      $display("FAIL reset_d4: got done=%0b pass=%0b fail=%0b mask=%h count=%0d, want all 0",
               d4_done, d4_pass, d4_fail, d4_mask, d4_count);
    end
  endtask

  task automatic test_single_pass();
    do_reset();
    st1[0] = 32'h1;
    checks++;
    if (d1_done !== 1'b0) begin
      errors++;
      $display("FAIL pass_latency: done=%0b before edge, want 0", d1_done);
    end
    step();
    checks++;
    if ({d1_done, d1_pass, d1_fail, d1_mask} !== 4'b1101) begin
      errors++;
      $display("FAIL single_pass: got done=%0b pass=%0b fail=%0b mask=%0b, want 1 1 0 1",
               d1_done, d1_pass, d1_fail, d1_mask);
    end
  endtask

  task automatic test_single_fail();
    do_reset();
    st1[0] = 32'h55;
    step();
    checks++;
    if ({d1_done, d1_pass, d1_fail} !== 3'b101 || d1_code !== 31'h2A || d1_idx !== 1'b0) begin
      errors++;
      $display("FAIL single_fail: got done=%0b pass=%0b fail=%0b code=%h idx=%0d, want 1 0 1 2a 0",
               d1_done, d1_pass, d1_fail, d1_code, d1_idx);
    end
    st1[0] = 32'h1;
    step();
    checks++;
    if ({d1_pass, d1_fail} !== 2'b01 || d1_code !== 31'h2A) begin
      errors++;
      $display("FAIL fail_sticky: got pass=%0b fail=%0b code=%h, want 0 1 2a", d1_pass, d1_fail, d1_code);
    end
  endtask

  task automatic test_ignore_even();
    do_reset();
    st1[0] = 32'h4;
    repeat (3) step();
    checks++;
    if (d1_done !== 1'b0 || d1_mask !== 1'b0) begin
      errors++;
      $display("FAIL ignore_even: got done=%0b mask=%0b, want 0 0", d1_done, d1_mask);
    end
  endtask

  task automatic test_multi_fail();
    do_reset();
    st4[1] = 32'h7;
    st4[3] = 32'h5;
    step();
    checks++;
    if ({d4_done, d4_fail, d4_pass} !== 3'b110 || d4_idx !== 2'd1 || d4_code !== 31'd3 || d4_mask !== 4'b1010) begin
      errors++;
      $display("FAIL multi_fail: got done=%0b fail=%0b pass=%0b idx=%0d code=%0d mask=%b, want 1 1 0 1 3 1010",
               d4_done, d4_fail, d4_pass, d4_idx, d4_code, d4_mask);
    end
    st4[0] = 32'h1;
    step();
    step();
    checks++;
    if ({d4_done, d4_fail, d4_pass} !== 3'b110 || d4_idx !== 2'd1 || d4_code !== 31'd3 || d4_mask !== 4'b1010) begin
      errors++;
      $display("FAIL multi_fail_hold: got done=%0b fail=%0b pass=%0b idx=%0d code=%0d mask=%b, want 1 1 0 1 3 1010",
               d4_done, d4_fail, d4_pass, d4_idx, d4_code, d4_mask);
    end
  endtask

  task automatic test_staggered();
    do_reset();
    st4[2] = 32'h2;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc == 10) st4[0] = 32'h1;
      if (cyc == 20) st4[1] = 32'h1;
      if (cyc == 30) st4[2] = 32'h1;
      if (cyc == 40) st4[3] = 32'h1;
      if (cyc == 40) begin
        checks++;
        if (d4_done !== 1'b0 || d4_mask !== 4'b0111) begin
          errors++;
          $display("FAIL staggered_early: got done=%0b mask=%b, want 0 0111", d4_done, d4_mask);
        end
      end
      step();
    end
    checks++;
    if ({d4_done, d4_pass, d4_fail} !== 3'b110 || d4_mask !== 4'hF || d4_count !== 64'd40) begin
      errors++;
      $display("FAIL staggered_done: got done=%0b pass=%0b fail=%0b mask=%h count=%0d, want 1 1 0 f 40",
               d4_done, d4_pass, d4_fail, d4_mask, d4_count);
    end
  endtask

  task automatic test_fail_wins();
    do_reset();
    st4[0] = 32'h1;
    st4[1] = 32'h1;
    step();
    st4[2] = 32'h1;
    st4[3] = 32'h3;
    step();
    checks++;
    if ({d4_done, d4_pass, d4_fail} !== 3'b101 || d4_idx !== 2'd3 || d4_code !== 31'd1) begin
      errors++;
      $display("FAIL fail_wins: got done=%0b pass=%0b fail=%0b idx=%0d code=%0d, want 1 0 1 3 1",
               d4_done, d4_pass, d4_fail, d4_idx, d4_code);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    st1[0] = 32'h55;
    step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({d1_done, d1_pass, d1_fail, d1_code, d1_mask} !== '0 || d1_count !== 64'd0) begin
      errors++;
      $display("FAIL reset_async: got done=%0b fail=%0b code=%h mask=%0b count=%0d, want all 0",
               d1_done, d1_fail, d1_code, d1_mask, d1_count);
    end
    @(negedge clock);
    step();
    checks++;
    if (d1_done !== 1'b0 || d1_mask !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores: got done=%0b mask=%0b, want 0 0", d1_done, d1_mask);
    end
    reset = 1'b1;
    st1[0] = 32'h1;
    step();
    checks++;
    if ({d1_done, d1_pass, d1_fail} !== 3'b110) begin
      errors++;
      $display("FAIL reset_then_pass: got done=%0b pass=%0b fail=%0b, want 1 1 0", d1_done, d1_pass, d1_fail);
    end
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef TEST_FINISHER_TIMEOUT_EN
    for (int n = 0; n < 150 && !d1_timeout; n++) step();
    checks++;
    if ({d1_timeout, d1_done, d1_fail, d1_pass} !== 4'b1110 || d1_code !== '1 || d1_idx !== 1'b0 ||
        d1_count !== 64'd101) begin
      errors++;
      $display("FAIL timeout: got to=%0b done=%0b fail=%0b pass=%0b code=%h idx=%0d count=%0d, want 1 1 1 0 7fffffff 0 101",
               d1_timeout, d1_done, d1_fail, d1_pass, d1_code, d1_idx, d1_count);
    end
`else
    repeat (150) step();
    checks++;
    if (d1_timeout !== 1'b0 || d1_done !== 1'b0 || d1_count !== 64'd150) begin
      errors++;
      $display("FAIL no_timeout: got to=%0b done=%0b count=%0d, want 0 0 150", d1_timeout, d1_done, d1_count);
    end
`endif
  endtask

  initial begin
    st1[0] = '0;
    for (int i = 0; i < 4; i++) st4[i] = '0;
    @(negedge clock);
    test_reset();
    test_single_pass();
    test_single_fail();
    test_ignore_even();
    test_multi_fail();
    test_staggered();
    test_fail_wins();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
